control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Instruction sequencer for the CSC244 processor: the producer side of the datapath/display interface.
//  Captures a 10-bit instruction from the switches and walks it through timesteps T0..T3, one step per KEY press.
//  Drives the datapath bus-drive enables, one-cycle load pulses, ALU op, TIME and DONE toward OutputLogic.
//  Sits between the debounced KEY0/switch inputs and the register file/ALU.
// PARAMETERS
//  W     10  data/instruction width
//  NREG  4   number of general registers; Rx/Ry fields are $clog2(NREG) bits
// PORTS
//  CLK50MHz    in   1        single system clock; all state on posedge
//  RSTb        in   1        reset, asynchronous, active-low
//  STEPb       in   1        debounced step key, active-low level (pressed = 0)
//  IN_DATA_BUS in   W        switches; instruction source at T0, immediate at LOAD T1
//  EXT_EN      out  1        level: switches drive BUS
//  ROUT        out  NREG     level, one-hot/zero: register drives BUS
//  G_OUT       out  1        level: G register drives BUS
//  RIN         out  NREG     one-cycle pulse: register loads BUS
//  A_LD, G_LD  out  1 each   one-cycle pulse: A loads BUS / G loads ALU result
//  ALU_OP      out  3        level: opcode to ALU, valid whenever G_LD can pulse
//  REG_SEL     out  2        level: IR.Rx, display register select
//  TIME        out  2        current timestep 0..3
//  DONE        out  1        level: current timestep is the instruction's last
// BEHAVIOUR
//  Reset (RSTb=0, async): TIME=0, IR=0, key history=0; all enables/pulses 0; DONE=0.
//  Step detect: stp = key_prev & ~STEPb (registered falling edge); exactly one stp per press.
//   key_prev resets to 0, so a key held through reset generates no step until released and re-pressed.
//  Load pulses (RIN, A_LD, G_LD) = decode(TIME,IR) & stp; asserted in the stp cycle only.
//  TIME/IR update on the clock edge ending the stp cycle. New level outputs are visible the next cycle.
//  IR format: op=IR[9:7], Rx=IR[6:5], Ry=IR[4:3], IR[2:0] ignored.
//  op: 000 LOAD, 001 MOV, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 NOT.
//  ALU_OP = IR.op. REG_SEL = IR.Rx.
//  Timestep states (enum): T0, T1, T2, T3.
//   T0 all ops: EXT_EN=1; on stp: IR<=IN_DATA_BUS, ->T1 (no RIN).
//   LOAD T1: EXT_EN, RIN[Rx] on stp; DONE.
//   MOV  T1: ROUT[Ry], RIN[Rx] on stp; DONE.
//   NOT  T1: ROUT[Ry], G_LD on stp.
//   NOT  T2: G_OUT, RIN[Rx] on stp; DONE.
//   2-op (ADD..XOR) T1: ROUT[Rx], A_LD on stp.
//   2-op (ADD..XOR) T2: ROUT[Ry], G_LD on stp.
//   2-op (ADD..XOR) T3: G_OUT, RIN[Rx] on stp; DONE.
//  Step while DONE=1 -> T0 (TIME=0, DONE=0). Otherwise TIME+1.
//  Never TIME wraps 3->0 without DONE; illegal/unreached state -> T0.
//  Bus drive exclusivity: at most one of EXT_EN, ROUT bits, G_OUT high in any cycle (assertion).
//  Mid-instruction reset: immediate return to T0; no pulse in the reset cycle.
//  Switch changes outside a stp cycle have no effect on IR.
//  Rx==Ry is legal (e.g. ADD R1,R1 doubles R1).
// STRUCTURE
//  cpu_pkg: opcode_t enum (8 ops, 3 bits), tstep_t enum T0..T3, IR field slice constants.
//  cpu_pkg is shared with the ALU and OutputLogic.
//  Sub-module step_edge: key_prev flop plus falling-edge pulse, reused for PKb.
//  Sequencer body: one always_ff (TIME, IR) plus one always_comb decode.
// TESTING
//  1. Reset, STEPb held 0 through RSTb rise -> no stp, TIME=0. Release then press -> TIME=1.
//  2. Switches 10'b000_01_00_000, press x2 -> T0 EXT_EN; T1 EXT_EN + RIN=0010 pulse + DONE.
//     Third press -> TIME=0, DONE=0.
//  3. ADD R2,R3 (10'b010_10_11_000), 4 presses:
//     T1 ROUT=0100/A_LD; T2 ROUT=1000/G_LD, ALU_OP=010; T3 G_OUT/RIN=0100/DONE.
//  4. NOT R0,R1 (10'b111_00_01_000) -> T1 ROUT=0010/G_LD; T2 G_OUT/RIN=0001; DONE at TIME=2.
//  5. RSTb pulsed low during ADD T2 -> TIME=0, ROUT=0, no RIN; next instruction runs normally.
//  6. Switches toggled between presses during SUB -> IR/REG_SEL unchanged.
//     Every cycle: one-hot bus drive, and pulses only in stp cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Purpose: shared CSC244 processor types (opcodes, timesteps, IR field layout)
//          used by the sequencer, ALU and OutputLogic.
package cpu_pkg;

    localparam int unsigned IR_W      = 10;
    localparam int unsigned OP_W      = 3;
    localparam int unsigned RSEL_W    = 2;
    localparam int unsigned IR_OP_LSB = 7;
    localparam int unsigned IR_RX_LSB = 5;
    localparam int unsigned IR_RY_LSB = 3;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD = 3'd0,
        OP_MOV  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_XOR  = 3'd6,
        OP_NOT  = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_t;

endpackage

// File: rtl/step_edge.sv
// Purpose: turns a debounced active-low key level into a single-cycle step
//          pulse on its falling edge.
// Ports:
//   i_clk    system clock
//   i_rst_n  async active-low reset
//   i_key_n  debounced key level, pressed = 0
//   o_stp_c  combinational pulse, high for the one cycle after the press
module step_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_stp_c
);

    logic r_key_prev;

    // Resets to 0 so a key held through reset must be released before it counts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_key_prev <= 1'b0;
        end else begin
            r_key_prev <= i_key_n;
        end
    end

    assign o_stp_c = r_key_prev & ~i_key_n;

endmodule

// File: rtl/control_sequencer.sv
// Purpose: instruction sequencer for the CSC244 processor. Captures an
//          instruction from the switches at T0 and walks it through T1..T3,
//          one timestep per key press, driving bus enables and load pulses.
// Ports:
//   CLK50MHz     system clock
//   RSTb         async active-low reset
//   STEPb        debounced step key, pressed = 0
//   IN_DATA_BUS  switches: instruction at T0, immediate at LOAD T1
//   EXT_EN       level: switches drive BUS
//   ROUT         level, one-hot/zero: register drives BUS
//   G_OUT        level: G drives BUS
//   RIN          pulse: register loads BUS
//   A_LD, G_LD   pulse: A loads BUS / G loads ALU result
//   ALU_OP       level: IR opcode
//   REG_SEL      level: IR.Rx for the display
//   TIME         current timestep
//   DONE         level: current timestep is the instruction's last
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned W    = 10,
    parameter int unsigned NREG = 4
) (
    input  logic                    CLK50MHz,
    input  logic                    RSTb,
    input  logic                    STEPb,
    input  logic [W-1:0]            IN_DATA_BUS,
    output logic                    EXT_EN,
    output logic [NREG-1:0]         ROUT,
    output logic                    G_OUT,
    output logic [NREG-1:0]         RIN,
    output logic                    A_LD,
    output logic                    G_LD,
    output logic [OP_W-1:0]         ALU_OP,
    output logic [$clog2(NREG)-1:0] REG_SEL,
    output logic [1:0]              TIME,
    output logic                    DONE
);

    localparam int unsigned RX_W = $clog2(NREG);

    logic            w_stp_c;
    tstep_t          r_time;
    tstep_t          w_time_next;
    logic [W-1:0]    r_ir;
    opcode_t         w_op;
    logic [RX_W-1:0] w_rx;
    logic [RX_W-1:0] w_ry;
    logic [NREG-1:0] w_rx_oh;
    logic [NREG-1:0] w_ry_oh;
    logic            w_ext_en;
    logic [NREG-1:0] w_rout;
    logic            w_g_out;
    logic [NREG-1:0] w_rin;
    logic            w_a_ld;
    logic            w_g_ld;
    logic            w_done;
    logic            w_ir_ld;
    logic            w_legal;
    logic            w_unused_ir_lsbs;

    step_edge u_step_edge (
        .i_clk   (CLK50MHz),
        .i_rst_n (RSTb),
        .i_key_n (STEPb),
        .o_stp_c (w_stp_c)
    );

    // IR field decode
    assign w_op             = opcode_t'(r_ir[IR_OP_LSB +: OP_W]);
    assign w_rx             = r_ir[IR_RX_LSB +: RX_W];
    assign w_ry             = r_ir[IR_RY_LSB +: RX_W];
    assign w_rx_oh          = NREG'(1) << w_rx;
    assign w_ry_oh          = NREG'(1) << w_ry;
    assign w_unused_ir_lsbs = ^r_ir[IR_RY_LSB-1:0];

    // Timestep and instruction register
    always_ff @(posedge CLK50MHz or negedge RSTb) begin
        if (!RSTb) begin
            r_time <= T0;
            r_ir   <= '0;
        end else begin
            r_time <= w_time_next;
            if (w_ir_ld) begin
                r_ir <= IN_DATA_BUS;
            end
        end
    end

    // Per-timestep decode; *_ld/w_rin are pulse candidates gated by the step below
    always_comb begin
        w_ext_en    = 1'b0;
        w_rout      = '0;
        w_g_out     = 1'b0;
        w_rin       = '0;
        w_a_ld      = 1'b0;
        w_g_ld      = 1'b0;
        w_done      = 1'b0;
        w_ir_ld     = 1'b0;
        w_legal     = 1'b1;
        w_time_next = r_time;

        case (r_time)
            T0: begin
                w_ext_en = 1'b1;
                w_ir_ld  = w_stp_c;
            end
            T1: begin
                case (w_op)
                    OP_LOAD: begin
                        w_ext_en = 1'b1;
                        w_rin    = w_rx_oh;
                        w_done   = 1'b1;
                    end
                    OP_MOV: begin
                        w_rout = w_ry_oh;
                        w_rin  = w_rx_oh;
                        w_done = 1'b1;
                    end
                    OP_NOT: begin
                        w_rout = w_ry_oh;
                        w_g_ld = 1'b1;
                    end
                    default: begin
                        w_rout = w_rx_oh;
                        w_a_ld = 1'b1;
                    end
                endcase
            end
            T2: begin
                case (w_op)
                    OP_LOAD, OP_MOV: w_legal = 1'b0;
                    OP_NOT: begin
                        w_g_out = 1'b1;
                        w_rin   = w_rx_oh;
                        w_done  = 1'b1;
                    end
                    default: begin
                        w_rout = w_ry_oh;
                        w_g_ld = 1'b1;
                    end
                endcase
            end
            T3: begin
                case (w_op)
                    OP_LOAD, OP_MOV, OP_NOT: w_legal = 1'b0;
                    default: begin
                        w_g_out = 1'b1;
                        w_rin   = w_rx_oh;
                        w_done  = 1'b1;
                    end
                endcase
            end
            default: w_legal = 1'b0;
        endcase

        // A timestep the opcode never reaches falls straight back to T0
        if (!w_legal) begin
            w_time_next = T0;
        end else if (w_stp_c) begin
            w_time_next = w_done ? T0 : tstep_t'(2'(r_time + 2'd1));
        end
    end

    // In reset r_time=T0 and r_ir=0, so EXT_EN is the only level needing a reset gate;
    // the step pulse is already 0 because the key history resets to 0.
    assign EXT_EN  = w_ext_en & RSTb;
    assign ROUT    = w_rout;
    assign G_OUT   = w_g_out;
    assign RIN     = w_rin & {NREG{w_stp_c}};
    assign A_LD    = w_a_ld & w_stp_c;
    assign G_LD    = w_g_ld & w_stp_c;
    assign ALU_OP  = r_ir[IR_OP_LSB +: OP_W];
    assign REG_SEL = w_rx;
    assign TIME    = r_time;
    assign DONE    = w_done;

    // At most one bus driver at a time
    a_bus_onehot0: assert property (@(posedge CLK50MHz) disable iff (!RSTb)
        $onehot0({EXT_EN, ROUT, G_OUT}));

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stepb;
    logic [9:0] sw;
    logic       EXT_EN, G_OUT, A_LD, G_LD, DONE;
    logic [3:0] ROUT, RIN;
    logic [2:0] ALU_OP;
    logic [1:0] REG_SEL, TIME;

    always #5 clk = ~clk;

    control_sequencer dut (
        .CLK50MHz    (clk),
        .RSTb        (rst_n),
        .STEPb       (stepb),
        .IN_DATA_BUS (sw),
        .EXT_EN      (EXT_EN),
        .ROUT        (ROUT),
        .G_OUT       (G_OUT),
        .RIN         (RIN),
        .A_LD        (A_LD),
        .G_LD        (G_LD),
        .ALU_OP      (ALU_OP),
        .REG_SEL     (REG_SEL),
        .TIME        (TIME),
        .DONE        (DONE)
    );

    typedef struct {
        logic [1:0] t;
        logic       ext;
        logic [3:0] rout;
        logic       gout;
        logic [3:0] rin;
        logic       ald;
        logic       gld;
        logic [2:0] alu;
        logic [1:0] rsel;
        logic       done;
    } exp_t;

    exp_t       sb[$];
    exp_t       p_stp;     // DUT outputs seen in the step cycle of the last press
    exp_t       p_after;   // DUT outputs seen once the last press settled
    exp_t       obs;
    int         checks = 0;
    int         errors = 0;
    string      phase  = "init";
    logic [1:0] m_time = 2'd0;
    logic [9:0] m_ir   = '0;
    bit         kprev  = 1'b0;

    // Reference: each opcode is a list of micro-steps, the last one writes back
    function automatic exp_t model(logic [1:0] t, logic [9:0] ir, bit stp, bit run);
        exp_t        e;
        logic [2:0]  op;
        int          rx, ry, last;
        e = '{default: '0};
        if (!run) return e;
        op   = ir[9:7];
        rx   = int'(ir[6:5]);
        ry   = int'(ir[4:3]);
        last = (op == 3'd0 || op == 3'd1) ? 1 : (op == 3'd7) ? 2 : 3;
        e.t    = t;
        e.alu  = op;
        e.rsel = ir[6:5];
        if (t == 2'd0) begin
            e.ext = 1'b1;
        end else if (int'(t) == last) begin
            e.done = 1'b1;
            if (stp) e.rin = 4'(1) << rx;
            if (op == 3'd0)      e.ext  = 1'b1;
            else if (op == 3'd1) e.rout = 4'(1) << ry;
            else                 e.gout = 1'b1;
        end else if (t == 2'd1) begin
            if (op == 3'd7) begin
                e.rout = 4'(1) << ry;
                e.gld  = stp;
            end else begin
                e.rout = 4'(1) << rx;
                e.ald  = stp;
            end
        end else begin
            e.rout = 4'(1) << ry;
            e.gld  = stp;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, o, x);
        end
    endtask

    // One clock: inputs already driven just after posedge; sample at negedge
    task automatic check_cycle();
        exp_t e;
        bit   stp;
        if (!rst_n) begin
            m_time = 2'd0;
            m_ir   = '0;
            kprev  = 1'b0;
        end
        stp = kprev && !stepb && rst_n;
        sb.push_back(model(m_time, m_ir, stp, rst_n));
        @(negedge clk);
        e   = sb.pop_front();
        obs = '{TIME, EXT_EN, ROUT, G_OUT, RIN, A_LD, G_LD, ALU_OP, REG_SEL, DONE};
        chk("time",    32'(obs.t),    32'(e.t));
        chk("ext_en",  32'(obs.ext),  32'(e.ext));
        chk("rout",    32'(obs.rout), 32'(e.rout));
        chk("g_out",   32'(obs.gout), 32'(e.gout));
        chk("rin",     32'(obs.rin),  32'(e.rin));
        chk("a_ld",    32'(obs.ald),  32'(e.ald));
        chk("g_ld",    32'(obs.gld),  32'(e.gld));
        chk("alu_op",  32'(obs.alu),  32'(e.alu));
        chk("reg_sel", 32'(obs.rsel), 32'(e.rsel));
        chk("done",    32'(obs.done), 32'(e.done));
        chk("bus_onehot0", 32'($onehot0({EXT_EN, ROUT, G_OUT})), 32'(1));
        chk("pulse_outside_stp", 32'((|RIN | A_LD | G_LD) & ~stp), 32'(0));
        if (rst_n) begin
            if (stp) begin
                if (m_time == 2'd0) m_ir = sw;
                m_time = e.done ? 2'd0 : m_time + 2'd1;
            end
            kprev = stepb;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        stepb = 1'b0;
        check_cycle();
        p_stp = obs;
        check_cycle();
        stepb = 1'b1;
        check_cycle();
        p_after = obs;
    endtask

    initial begin
        rst_n = 1'b0;
        stepb = 1'b0;
        sw    = '0;

        // 1. key held through reset release gives no step
        phase = "reset";
        repeat (3) check_cycle();
        chk("rst_ext_en", 32'(obs.ext), 32'(0));
        chk("rst_time",   32'(obs.t),   32'(0));
        rst_n = 1'b1;
        repeat (3) check_cycle();
        chk("held_time", 32'(obs.t), 32'(0));
        stepb = 1'b1;
        repeat (2) check_cycle();
        press();
        chk("first_press_time", 32'(p_after.t), 32'(1));
        press();
        chk("first_instr_end", 32'(p_after.t), 32'(0));

        // 2. LOAD R1
        phase = "load";
        sw = 10'b000_01_00_000;
        press();
        chk("t0_ext_en", 32'(p_stp.ext), 32'(1));
        chk("t0_rin",    32'(p_stp.rin), 32'(0));
        chk("t1_done",   32'(p_after.done), 32'(1));
        press();
        chk("t1_rin",    32'(p_stp.rin), 32'(4'b0010));
        chk("t1_ext_en", 32'(p_stp.ext), 32'(1));
        chk("end_time",  32'(p_after.t), 32'(0));
        chk("end_done",  32'(p_after.done), 32'(0));

        // 3. ADD R2,R3
        phase = "add";
        sw = 10'b010_10_11_000;
        press();
        press();
        chk("t1_rout", 32'(p_stp.rout), 32'(4'b0100));
        chk("t1_a_ld", 32'(p_stp.ald),  32'(1));
        press();
        chk("t2_rout",   32'(p_stp.rout), 32'(4'b1000));
        chk("t2_g_ld",   32'(p_stp.gld),  32'(1));
        chk("t2_alu_op", 32'(p_stp.alu),  32'(3'b010));
        chk("t3_time",   32'(p_after.t),  32'(3));
        press();
        chk("t3_g_out", 32'(p_stp.gout), 32'(1));
        chk("t3_rin",   32'(p_stp.rin),  32'(4'b0100));
        chk("t3_done",  32'(p_stp.done), 32'(1));
        chk("end_time", 32'(p_after.t),  32'(0));

        // 4. NOT R0,R1
        phase = "not";
        sw = 10'b111_00_01_000;
        press();
        press();
        chk("t1_rout",  32'(p_stp.rout),   32'(4'b0010));
        chk("t1_g_ld",  32'(p_stp.gld),    32'(1));
        chk("t2_done",  32'(p_after.done), 32'(1));
        chk("t2_time",  32'(p_after.t),    32'(2));
        press();
        chk("t2_g_out", 32'(p_stp.gout), 32'(1));
        chk("t2_rin",   32'(p_stp.rin),  32'(4'b0001));
        chk("end_time", 32'(p_after.t),  32'(0));

        // 5. reset during ADD T2, then MOV R3,R0 runs normally
        phase = "midreset";
        sw = 10'b010_10_11_000;
        press();
        press();
        rst_n = 1'b0;
        check_cycle();
        chk("rst_time", 32'(obs.t),    32'(0));
        chk("rst_rout", 32'(obs.rout), 32'(0));
        chk("rst_rin",  32'(obs.rin),  32'(0));
        rst_n = 1'b1;
        repeat (2) check_cycle();
        sw = 10'b001_11_00_000;
        press();
        press();
        chk("mov_rout", 32'(p_stp.rout), 32'(4'b0001));
        chk("mov_rin",  32'(p_stp.rin),  32'(4'b1000));
        chk("mov_end",  32'(p_after.t),  32'(0));

        // 6. SUB R1,R2 with switches wiggled between presses
        phase = "sub";
        sw = 10'b011_01_10_000;
        press();
        for (int i = 0; i < 3; i++) begin
            sw = 10'($urandom);
            check_cycle();
            press();
            chk("reg_sel_hold", 32'(p_after.rsel), 32'(2'b01));
            chk("alu_op_hold",  32'(p_after.alu),  32'(3'b011));
        end
        chk("sub_end", 32'(p_after.t), 32'(0));

        // ADD R1,R1: same register on both operands
        phase = "add_same";
        sw = 10'b010_01_01_000;
        press();
        press();
        chk("t1_rout", 32'(p_stp.rout), 32'(4'b0010));
        press();
        chk("t2_rout", 32'(p_stp.rout), 32'(4'b0010));
        press();
        chk("t3_rin",  32'(p_stp.rin),  32'(4'b0010));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
